// File: rtl/a2mem_pkg.sv
// ============================================================================
// Module   : a2mem_pkg
// Brief    : Shared addresses, reset colours, switch indices and kbd FSM type
// Revision : 1.0
// ============================================================================
`default_nettype none

package a2mem_pkg;

    localparam logic [15:0] SW_IIE_BASE    = 16'hC000;
    localparam logic [15:0] SW_VID_BASE    = 16'hC050;
    localparam logic [15:0] KBD_CLR_BASE   = 16'hC010;
    localparam logic [15:0] IIGS_MONO      = 16'hC021;
    localparam logic [15:0] IIGS_TEXTCOL   = 16'hC022;
    localparam logic [15:0] IIGS_NEWVIDEO  = 16'hC029;
    localparam logic [15:0] IIGS_BORDER    = 16'hC034;
    localparam logic [15:0] C8_OFF         = 16'hCFFF;

    localparam logic [3:0]  RST_TEXT_COLOR   = 4'hF;
    localparam logic [3:0]  RST_BG_COLOR     = 4'h6;
    localparam logic [3:0]  RST_BORDER_COLOR = 4'h6;

    // Bit positions inside the IIe and video switch vectors (address[3:1])
    localparam int IIE_STORE80   = 0;
    localparam int IIE_RAMRD     = 1;
    localparam int IIE_RAMWRT    = 2;
    localparam int IIE_INTCXROM  = 3;
    localparam int IIE_ALTZP     = 4;
    localparam int IIE_SLOTC3ROM = 5;
    localparam int IIE_COL80     = 6;
    localparam int IIE_ALTCHAR   = 7;

    localparam int VID_TEXT      = 0;
    localparam int VID_MIXED     = 1;
    localparam int VID_PAGE2     = 2;
    localparam int VID_HIRES     = 3;
    localparam int VID_AN0       = 4;
    localparam int VID_AN1       = 5;
    localparam int VID_AN2       = 6;
    localparam int VID_AN3       = 7;

    typedef enum logic [0:0] {
        ARMED = 1'b0,
        HELD  = 1'b1
    } kbd_state_t;

    function automatic logic page16_hit(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:4] == base[15:4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/a2mem_if.sv
// ============================================================================
// Module   : a2mem_if
// Brief    : Apple II memory-state bundle: soft switches, IIgs config, kbd, aux
// Revision : 1.0
// ============================================================================
`default_nettype none

interface a2mem_if;
    logic       STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR;
    logic       TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3;
    logic [2:0] SLOTROM;
    logic       INTC8ROM;
    logic       MONOCHROME_MODE, SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE;
    logic [3:0] TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR;
    logic [7:0] keycode;
    logic       keypress_strobe;
    logic       aux_mem;

    modport master (
        output STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
        output TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
        output SLOTROM, INTC8ROM,
        output MONOCHROME_MODE, SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE,
        output TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
        output keycode, keypress_strobe, aux_mem
    );

    modport slave (
        input STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
        input TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
        input SLOTROM, INTC8ROM,
        input MONOCHROME_MODE, SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE,
        input TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
        input keycode, keypress_strobe, aux_mem
    );
endinterface

`default_nettype wire

// File: rtl/a2mem_kbd_latch.sv
// ============================================================================
// Module   : a2mem_kbd_latch
// Brief    : Keyboard latch; one strobe per key until re-armed
// Revision : 1.0
// ============================================================================
`default_nettype none

module a2mem_kbd_latch
    import a2mem_pkg::*;
(
    input  logic       clk_logic_i,
    input  logic       reset_i,
    input  logic       i_key_rd,
    input  logic       i_rearm,
    input  logic [7:0] i_data,
    output logic [7:0] o_keycode,
    output logic       o_keypress_strobe
);

    kbd_state_t r_state;
    logic [7:0] r_keycode;
    logic       r_strobe;

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ARMED;
            r_keycode <= 8'h00;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ARMED: begin
                    if (i_key_rd && i_data[7]) begin
                        r_keycode <= i_data;
                        r_strobe  <= 1'b1;
                        r_state   <= HELD;
                    end
                end
                HELD: begin
                    if (i_rearm || (i_key_rd && !i_data[7])) begin
                        r_state <= ARMED;
                    end
                end
                default: r_state <= ARMED;
            endcase
        end
    end

    assign o_keycode         = r_keycode;
    assign o_keypress_strobe = r_strobe;

endmodule

`default_nettype wire

// File: rtl/a2mem_softsw.sv
// ============================================================================
// Module   : a2mem_softsw
// Brief    : Bus-snooping soft-switch decoder driving the a2mem_if master side
// Revision : 1.0
// ============================================================================
`default_nettype none

module a2mem_softsw
    import a2mem_pkg::*;
#(
    parameter int ENABLE_IIGS = 1,
    parameter int ENABLE_AUX  = 1
) (
    input  logic        clk_logic_i,
    input  logic        reset_i,
    input  logic        bus_strobe_i,
    input  logic [15:0] bus_addr_i,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_rw_n_i,
    a2mem_if.master     a2mem
);

    logic [7:0] r_iie_sw;
    logic [7:0] r_vid_sw;
    logic [2:0] r_slotrom;
    logic       r_intc8rom;
    logic       r_mono;
    logic       r_shrg;
    logic       r_linear;
    logic       r_mono_dhires;
    logic [3:0] r_text_color;
    logic [3:0] r_bg_color;
    logic [3:0] r_border_color;
    logic       r_aux_mem;

    logic       w_wr;
    logic       w_iie_hit;
    logic       w_vid_hit;
    logic       w_kbd_rd;
    logic       w_kbd_clr;
    logic [2:0] w_cn_slot;
    logic       w_cn_hit;
    logic       w_c8_off;
    logic       w_iigs_wr;
    logic       w_sel;
    logic       w_aux;

    assign w_wr      = bus_strobe_i && !bus_rw_n_i;
    assign w_iie_hit = w_wr && page16_hit(bus_addr_i, SW_IIE_BASE);
    assign w_vid_hit = bus_strobe_i && page16_hit(bus_addr_i, SW_VID_BASE);
    assign w_kbd_rd  = bus_strobe_i && bus_rw_n_i && (bus_addr_i == SW_IIE_BASE);
    assign w_kbd_clr = bus_strobe_i && page16_hit(bus_addr_i, KBD_CLR_BASE);
    assign w_cn_slot = bus_addr_i[10:8];
    assign w_cn_hit  = (bus_addr_i[15:11] == 5'b11000) && (w_cn_slot != 3'd0);
    assign w_c8_off  = bus_addr_i == C8_OFF;
    assign w_iigs_wr = (ENABLE_IIGS != 0) && w_wr;

    // Aux decode uses the switch state before this cycle's own update
    always_comb begin
        w_sel = bus_rw_n_i ? r_iie_sw[IIE_RAMRD] : r_iie_sw[IIE_RAMWRT];
        w_aux = w_sel;
        if (bus_addr_i[15:14] == 2'b11) begin
            w_aux = 1'b0;
        end else if (bus_addr_i[15:9] == 7'd0) begin
            w_aux = r_iie_sw[IIE_ALTZP];
        end else if (bus_addr_i[15:10] == 6'b000001) begin
            w_aux = r_iie_sw[IIE_STORE80] ? r_vid_sw[VID_PAGE2] : w_sel;
        end else if (bus_addr_i[15:13] == 3'b001) begin
            w_aux = (r_iie_sw[IIE_STORE80] && r_vid_sw[VID_HIRES]) ? r_vid_sw[VID_PAGE2] : w_sel;
        end
    end

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            r_iie_sw       <= 8'h00;
            r_vid_sw       <= 8'h01;
            r_slotrom      <= 3'd0;
            r_intc8rom     <= 1'b0;
            r_mono         <= 1'b0;
            r_shrg         <= 1'b0;
            r_linear       <= 1'b0;
            r_mono_dhires  <= 1'b0;
            r_text_color   <= RST_TEXT_COLOR;
            r_bg_color     <= RST_BG_COLOR;
            r_border_color <= RST_BORDER_COLOR;
            r_aux_mem      <= 1'b0;
        end else if (bus_strobe_i) begin
            if (w_iie_hit) begin
                r_iie_sw[bus_addr_i[3:1]] <= bus_addr_i[0];
            end
            if (w_vid_hit) begin
                r_vid_sw[bus_addr_i[3:1]] <= bus_addr_i[0];
            end

            if (w_c8_off) begin
                r_slotrom  <= 3'd0;
                r_intc8rom <= 1'b0;
            end else if (w_cn_hit && !r_iie_sw[IIE_INTCXROM]) begin
                r_slotrom <= w_cn_slot;
                if (w_cn_slot == 3'd3 && !r_iie_sw[IIE_SLOTC3ROM]) begin
                    r_intc8rom <= 1'b1;
                end
            end

            if (w_iigs_wr) begin
                if (bus_addr_i == IIGS_MONO) begin
                    r_mono <= bus_data_i[7];
                end
                if (bus_addr_i == IIGS_TEXTCOL) begin
                    r_text_color <= bus_data_i[7:4];
                    r_bg_color   <= bus_data_i[3:0];
                end
                if (bus_addr_i == IIGS_NEWVIDEO) begin
                    r_shrg        <= bus_data_i[7];
                    r_linear      <= bus_data_i[6];
                    r_mono_dhires <= bus_data_i[5];
                end
                if (bus_addr_i == IIGS_BORDER) begin
                    r_border_color <= bus_data_i[3:0];
                end
            end

            r_aux_mem <= (ENABLE_AUX != 0) ? w_aux : 1'b0;
        end
    end

    a2mem_kbd_latch u_kbd (
        .clk_logic_i       (clk_logic_i),
        .reset_i           (reset_i),
        .i_key_rd          (w_kbd_rd),
        .i_rearm           (w_kbd_clr),
        .i_data            (bus_data_i),
        .o_keycode         (a2mem.keycode),
        .o_keypress_strobe (a2mem.keypress_strobe)
    );

    assign a2mem.STORE80    = r_iie_sw[IIE_STORE80];
    assign a2mem.RAMRD      = r_iie_sw[IIE_RAMRD];
    assign a2mem.RAMWRT     = r_iie_sw[IIE_RAMWRT];
    assign a2mem.INTCXROM   = r_iie_sw[IIE_INTCXROM];
    assign a2mem.ALTZP      = r_iie_sw[IIE_ALTZP];
    assign a2mem.SLOTC3ROM  = r_iie_sw[IIE_SLOTC3ROM];
    assign a2mem.COL80      = r_iie_sw[IIE_COL80];
    assign a2mem.ALTCHAR    = r_iie_sw[IIE_ALTCHAR];
    assign a2mem.TEXT_MODE  = r_vid_sw[VID_TEXT];
    assign a2mem.MIXED_MODE = r_vid_sw[VID_MIXED];
    assign a2mem.PAGE2      = r_vid_sw[VID_PAGE2];
    assign a2mem.HIRES_MODE = r_vid_sw[VID_HIRES];
    assign a2mem.AN0        = r_vid_sw[VID_AN0];
    assign a2mem.AN1        = r_vid_sw[VID_AN1];
    assign a2mem.AN2        = r_vid_sw[VID_AN2];
    assign a2mem.AN3        = r_vid_sw[VID_AN3];

    assign a2mem.SLOTROM                = r_slotrom;
    assign a2mem.INTC8ROM               = r_intc8rom;
    assign a2mem.MONOCHROME_MODE        = r_mono;
    assign a2mem.SHRG_MODE              = r_shrg;
    assign a2mem.LINEARIZE_MODE         = r_linear;
    assign a2mem.MONOCHROME_DHIRES_MODE = r_mono_dhires;
    assign a2mem.TEXT_COLOR             = r_text_color;
    assign a2mem.BACKGROUND_COLOR       = r_bg_color;
    assign a2mem.BORDER_COLOR           = r_border_color;
    assign a2mem.aux_mem                = r_aux_mem;

endmodule

`default_nettype wire

// File: tb/tb_a2mem_softsw.sv
// ============================================================================
// Module   : tb_a2mem_softsw
// Brief    : Directed self-checking bench; full-feature and IIgs/aux-disabled DUTs
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_a2mem_softsw;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;

    int n_checks = 0;
    int n_fail   = 0;

    a2mem_if mem_a ();
    a2mem_if mem_b ();

    a2mem_softsw #(.ENABLE_IIGS(1), .ENABLE_AUX(1)) u_dut (
        .clk_logic_i  (clk),
        .reset_i      (rst),
        .bus_strobe_i (strobe),
        .bus_addr_i   (addr),
        .bus_data_i   (data),
        .bus_rw_n_i   (rw_n),
        .a2mem        (mem_a.master)
    );

    a2mem_softsw #(.ENABLE_IIGS(0), .ENABLE_AUX(0)) u_dut_lite (
        .clk_logic_i  (clk),
        .reset_i      (rst),
        .bus_strobe_i (strobe),
        .bus_addr_i   (addr),
        .bus_data_i   (data),
        .bus_rw_n_i   (rw_n),
        .a2mem        (mem_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bus cycle; returns on the negedge after the capturing posedge
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rd);
        @(negedge clk);
        addr   = a;
        data   = d;
        rw_n   = rd;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        strobe = 1'b0;
        addr   = 16'h0000;
        data   = 8'h00;
        rw_n   = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_text_mode",  8'(mem_a.TEXT_MODE), 8'h01);
        check("rst_text_color", 8'(mem_a.TEXT_COLOR), 8'h0F);
        check("rst_bg_color",   8'(mem_a.BACKGROUND_COLOR), 8'h06);
        check("rst_border",     8'(mem_a.BORDER_COLOR), 8'h06);
        check("rst_store80",    8'(mem_a.STORE80), 8'h00);
        check("rst_slotrom",    8'(mem_a.SLOTROM), 8'h00);
        check("rst_keycode",    mem_a.keycode, 8'h00);
        check("rst_aux",        8'(mem_a.aux_mem), 8'h00);
        rst = 1'b0;

        // IIe and video switches
        bus(16'hC001, 8'h00, 1'b0);
        check("store80_set", 8'(mem_a.STORE80), 8'h01);
        bus(16'hC00D, 8'h00, 1'b0);
        check("col80_set", 8'(mem_a.COL80), 8'h01);
        bus(16'hC057, 8'h00, 1'b1);
        check("hires_set", 8'(mem_a.HIRES_MODE), 8'h01);
        bus(16'hC050, 8'h00, 1'b1);
        check("text_clr", 8'(mem_a.TEXT_MODE), 8'h00);
        bus(16'hC001, 8'h00, 1'b1);
        check("store80_rd_noop", 8'(mem_a.STORE80), 8'h01);
        bus(16'hC051, 8'h00, 1'b0);
        check("text_set_wr", 8'(mem_a.TEXT_MODE), 8'h01);

        // Slot ROM
        bus(16'hC600, 8'h00, 1'b1);
        check("slotrom_6", 8'(mem_a.SLOTROM), 8'h06);
        bus(16'hC300, 8'h00, 1'b1);
        check("slotrom_3", 8'(mem_a.SLOTROM), 8'h03);
        check("intc8_set", 8'(mem_a.INTC8ROM), 8'h01);
        bus(16'hCFFF, 8'h00, 1'b1);
        check("slotrom_off", 8'(mem_a.SLOTROM), 8'h00);
        check("intc8_off", 8'(mem_a.INTC8ROM), 8'h00);
        bus(16'hC007, 8'h00, 1'b0);
        check("intcx_set", 8'(mem_a.INTCXROM), 8'h01);
        bus(16'hC500, 8'h00, 1'b1);
        check("slotrom_intcx", 8'(mem_a.SLOTROM), 8'h00);
        bus(16'hC006, 8'h00, 1'b0);

        // IIgs registers
        bus(16'hC022, 8'h2E, 1'b0);
        check("text_color",   8'(mem_a.TEXT_COLOR), 8'h02);
        check("bg_color",     8'(mem_a.BACKGROUND_COLOR), 8'h0E);
        check("lite_text",    8'(mem_b.TEXT_COLOR), 8'h0F);
        check("lite_bg",      8'(mem_b.BACKGROUND_COLOR), 8'h06);
        bus(16'hC029, 8'hC0, 1'b0);
        check("shrg",         8'(mem_a.SHRG_MODE), 8'h01);
        check("linearize",    8'(mem_a.LINEARIZE_MODE), 8'h01);
        check("mono_dhires",  8'(mem_a.MONOCHROME_DHIRES_MODE), 8'h00);
        check("lite_shrg",    8'(mem_b.SHRG_MODE), 8'h00);
        bus(16'hC034, 8'hF5, 1'b0);
        check("border",       8'(mem_a.BORDER_COLOR), 8'h05);
        check("lite_border",  8'(mem_b.BORDER_COLOR), 8'h06);
        bus(16'hC021, 8'h80, 1'b0);
        check("mono",         8'(mem_a.MONOCHROME_MODE), 8'h01);
        check("lite_mono",    8'(mem_b.MONOCHROME_MODE), 8'h00);

        // Keyboard latch
        bus(16'hC000, 8'hC1, 1'b1);
        check("kbd_strobe1", 8'(mem_a.keypress_strobe), 8'h01);
        check("kbd_code1",   mem_a.keycode, 8'hC1);
        check("kbd_rd_store80", 8'(mem_a.STORE80), 8'h01);
        bus(16'hC000, 8'hC1, 1'b1);
        check("kbd_nostrobe2", 8'(mem_a.keypress_strobe), 8'h00);
        bus(16'hC000, 8'hC1, 1'b1);
        check("kbd_nostrobe3", 8'(mem_a.keypress_strobe), 8'h00);
        check("kbd_code_held", mem_a.keycode, 8'hC1);
        bus(16'hC010, 8'h00, 1'b1);
        check("kbd_clr_nostrobe", 8'(mem_a.keypress_strobe), 8'h00);
        bus(16'hC000, 8'hC2, 1'b1);
        check("kbd_strobe2", 8'(mem_a.keypress_strobe), 8'h01);
        check("kbd_code2",   mem_a.keycode, 8'hC2);
        @(negedge clk);
        check("kbd_one_clock", 8'(mem_a.keypress_strobe), 8'h00);

        // Aux memory indicator (STORE80=1, HIRES=1 at this point)
        bus(16'hC055, 8'h00, 1'b1);
        check("page2_set", 8'(mem_a.PAGE2), 8'h01);
        bus(16'h0400, 8'h00, 1'b0);
        check("aux_80store_page2", 8'(mem_a.aux_mem), 8'h01);
        check("lite_aux_off",      8'(mem_b.aux_mem), 8'h00);
        bus(16'h2000, 8'h00, 1'b0);
        check("aux_hires_page2", 8'(mem_a.aux_mem), 8'h01);
        bus(16'hC000, 8'h00, 1'b0);
        check("store80_clr", 8'(mem_a.STORE80), 8'h00);
        bus(16'h0400, 8'h00, 1'b0);
        check("aux_ramwrt0", 8'(mem_a.aux_mem), 8'h00);
        bus(16'hC003, 8'h00, 1'b0);
        bus(16'h0800, 8'h00, 1'b1);
        check("aux_ramrd1", 8'(mem_a.aux_mem), 8'h01);
        bus(16'h0800, 8'h00, 1'b0);
        check("aux_wr_ramwrt0", 8'(mem_a.aux_mem), 8'h00);
        bus(16'hC001, 8'h00, 1'b0);
        bus(16'hC054, 8'h00, 1'b1);
        bus(16'h2000, 8'h00, 1'b1);
        check("aux_hires_page2_clr", 8'(mem_a.aux_mem), 8'h00);
        bus(16'hC009, 8'h00, 1'b0);
        bus(16'h0100, 8'h00, 1'b1);
        check("aux_altzp", 8'(mem_a.aux_mem), 8'h01);
        repeat (2) @(negedge clk);
        check("aux_hold", 8'(mem_a.aux_mem), 8'h01);
        bus(16'hE000, 8'h00, 1'b1);
        check("aux_rom", 8'(mem_a.aux_mem), 8'h00);
        bus(16'h0100, 8'h00, 1'b1);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_text_mode", 8'(mem_a.TEXT_MODE), 8'h01);
        check("arst_store80",   8'(mem_a.STORE80), 8'h00);
        check("arst_hires",     8'(mem_a.HIRES_MODE), 8'h00);
        check("arst_text_color", 8'(mem_a.TEXT_COLOR), 8'h0F);
        check("arst_border",    8'(mem_a.BORDER_COLOR), 8'h06);
        check("arst_keycode",   mem_a.keycode, 8'h00);
        check("arst_aux",       8'(mem_a.aux_mem), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
